// File: rtl/atconv_sched.sv
// rtl/atconv_sched.sv - address/strobe sequencer for the ATCONV dilated-conv + max-pool accelerator
module atconv_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        busy,
    output logic [11:0] iaddr,
    output logic        crd,
    output logic [11:0] caddr_rd,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic        csel,
    output logic        mac_clr,
    output logic        mac_en,
    output logic [3:0]  mac_tap,
    output logic        pool_clr,
    output logic        pool_en,
    output logic        out_sel
);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_WR0, S_POOL, S_WR1, S_DONE} state_t;

    state_t      state;
    logic [11:0] p;
    logic [3:0]  k;
    logic [9:0]  q;
    logic [1:0]  j;

    // base + 2*step - 2, clamped to 0..63; a negative sum wraps above 127 and sets bit 7
    function automatic logic [5:0] clamp_off(input logic [5:0] base, input logic [1:0] step);
        logic [7:0] s;
        s = {2'b00, base} + {5'b00000, step, 1'b0} - 8'd2;
        if (s[7])
            return 6'd0;
        else if (s > 8'd63)
            return 6'd63;
        else
            return s[5:0];
    endfunction

    function automatic logic [11:0] conv_addr(input logic [11:0] pix, input logic [3:0] tap);
        logic [1:0] ti;
        logic [1:0] tj;
        ti = (tap >= 4'd6) ? 2'd2 : (tap >= 4'd3) ? 2'd1 : 2'd0;
        case (tap)
            4'd0, 4'd3, 4'd6: tj = 2'd0;
            4'd1, 4'd4, 4'd7: tj = 2'd1;
            default:          tj = 2'd2;
        endcase
        return {clamp_off(pix[11:6], ti), clamp_off(pix[5:0], tj)};
    endfunction

    // window element e: row = 2r + e[1], col = 2c + e[0]
    function automatic logic [11:0] pool_addr(input logic [9:0] qq, input logic [1:0] e);
        return {qq[9:5], e[1], qq[4:0], e[0]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            p        <= 12'd0;
            k        <= 4'd0;
            q        <= 10'd0;
            j        <= 2'd0;
            busy     <= 1'b0;
            iaddr    <= 12'd0;
            crd      <= 1'b0;
            caddr_rd <= 12'd0;
            cwr      <= 1'b0;
            caddr_wr <= 12'd0;
            csel     <= 1'b0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_tap  <= 4'd0;
            pool_clr <= 1'b0;
            pool_en  <= 1'b0;
            out_sel  <= 1'b0;
        end else begin
            // outputs describe the state being entered; anything not set below returns to 0
            iaddr    <= 12'd0;
            crd      <= 1'b0;
            caddr_rd <= 12'd0;
            cwr      <= 1'b0;
            caddr_wr <= 12'd0;
            csel     <= 1'b0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_tap  <= 4'd0;
            pool_clr <= 1'b0;
            pool_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        state   <= S_CONV;
                        p       <= 12'd0;
                        k       <= 4'd0;
                        busy    <= 1'b1;
                        mac_en  <= 1'b1;
                        mac_clr <= 1'b1;
                        iaddr   <= conv_addr(12'd0, 4'd0);
                    end
                end
                S_CONV: begin
                    if (k == 4'd8) begin
                        state    <= S_WR0;
                        cwr      <= 1'b1;
                        caddr_wr <= p;
                        out_sel  <= 1'b0;
                    end else begin
                        k       <= k + 4'd1;
                        mac_en  <= 1'b1;
                        mac_tap <= k + 4'd1;
                        iaddr   <= conv_addr(p, k + 4'd1);
                    end
                end
                S_WR0: begin
                    if (p == 12'd4095) begin
                        state    <= S_POOL;
                        q        <= 10'd0;
                        j        <= 2'd0;
                        crd      <= 1'b1;
                        pool_en  <= 1'b1;
                        pool_clr <= 1'b1;
                        caddr_rd <= pool_addr(10'd0, 2'd0);
                    end else begin
                        state   <= S_CONV;
                        p       <= p + 12'd1;
                        k       <= 4'd0;
                        mac_en  <= 1'b1;
                        mac_clr <= 1'b1;
                        iaddr   <= conv_addr(p + 12'd1, 4'd0);
                    end
                end
                S_POOL: begin
                    if (j == 2'd3) begin
                        state    <= S_WR1;
                        cwr      <= 1'b1;
                        csel     <= 1'b1;
                        caddr_wr <= {2'b00, q};
                        out_sel  <= 1'b1;
                    end else begin
                        j        <= j + 2'd1;
                        crd      <= 1'b1;
                        pool_en  <= 1'b1;
                        caddr_rd <= pool_addr(q, j + 2'd1);
                    end
                end
                S_WR1: begin
                    if (q == 10'd1023) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= S_POOL;
                        q        <= q + 10'd1;
                        j        <= 2'd0;
                        crd      <= 1'b1;
                        pool_en  <= 1'b1;
                        pool_clr <= 1'b1;
                        caddr_rd <= pool_addr(q + 10'd1, 2'd0);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atconv_sched.sv
// tb/tb_atconv_sched.sv - scoreboard bench for atconv_sched with a behavioural datapath model
module tb_atconv_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic        csel;
    logic        mac_clr;
    logic        mac_en;
    logic [3:0]  mac_tap;
    logic        pool_clr;
    logic        pool_en;
    logic        out_sel;

    atconv_sched dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .crd(crd), .caddr_rd(caddr_rd), .cwr(cwr),
        .caddr_wr(caddr_wr), .csel(csel), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_tap(mac_tap), .pool_clr(pool_clr), .pool_en(pool_en), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] iaddr;
        logic        mac_en;
        logic        mac_clr;
        logic [3:0]  tap;
        logic        crd;
        logic        pool_en;
        logic        pool_clr;
        logic [11:0] rd;
        logic        cwr;
        logic [11:0] wr;
        logic        csel;
        logic        out_sel;
    } exp_t;

    localparam int RUN_LEN = 46080;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int img[4096];
    int w[9];
    int bias;
    int gold0[4096];
    int gold1[1024];
    int mem0[4096];
    int mem1[1024];
    int wc0[4096];
    int wc1[1024];

    logic [11:0] obs_iaddr[RUN_LEN];
    logic [11:0] obs_rd[RUN_LEN];
    logic [11:0] obs_wr[RUN_LEN];
    logic        obs_csel[RUN_LEN];

    int run_no   = 0;
    int busy_run = 0;
    int last_len = 0;
    logic busy_d = 1'b0;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : (v > 63) ? 63 : v;
    endfunction

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int roundup16(input int v);
        return ((v + 15) / 16) * 16;
    endfunction

    // Expected per-cycle control word for one whole run, straight from the cycle schedule
    task automatic push_run();
        exp_t e;
        for (int p = 0; p < 4096; p++) begin
            int r;
            int c;
            r = p / 64;
            c = p % 64;
            for (int k = 0; k < 9; k++) begin
                e = '0;
                e.mac_en  = 1'b1;
                e.mac_clr = (k == 0);
                e.tap     = 4'(k);
                e.iaddr   = 12'(clampi(r + 2 * (k / 3) - 2) * 64 + clampi(c + 2 * (k % 3) - 2));
                exp_q.push_back(e);
            end
            e = '0;
            e.cwr = 1'b1;
            e.wr  = 12'(p);
            exp_q.push_back(e);
        end
        for (int qq = 0; qq < 1024; qq++) begin
            int r;
            int c;
            r = qq / 32;
            c = qq % 32;
            for (int m = 0; m < 4; m++) begin
                e = '0;
                e.crd      = 1'b1;
                e.pool_en  = 1'b1;
                e.pool_clr = (m == 0);
                e.rd       = 12'((2 * r + m / 2) * 64 + 2 * c + m % 2);
                exp_q.push_back(e);
            end
            e = '0;
            e.cwr     = 1'b1;
            e.wr      = 12'(qq);
            e.csel    = 1'b1;
            e.out_sel = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: scoreboard pop per busy cycle, quiet check otherwise, datapath model for run 2
    initial begin
        exp_t act;
        exp_t e;
        int   acc;
        int   pmax;
        int   v;
        acc  = 0;
        pmax = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_d) begin
                run_no++;
                busy_run = 0;
            end
            if (!busy && busy_d)
                last_len = busy_run;
            busy_d = busy;
            if (busy) begin
                act          = '0;
                act.iaddr    = mac_en ? iaddr : 12'd0;
                act.mac_en   = mac_en;
                act.mac_clr  = mac_clr;
                act.tap      = mac_tap;
                act.crd      = crd;
                act.pool_en  = pool_en;
                act.pool_clr = pool_clr;
                act.rd       = caddr_rd;
                act.cwr      = cwr;
                act.wr       = caddr_wr;
                act.csel     = csel;
                act.out_sel  = cwr ? out_sel : 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seq_extra run %0d cycle %0d: got busy=1, expected no busy cycle", run_no, busy_run);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL seq run %0d cycle %0d: got %h, expected %h", run_no, busy_run, act, e);
                    end
                end
                if (run_no == 2 && busy_run < RUN_LEN) begin
                    obs_iaddr[busy_run] = iaddr;
                    obs_rd[busy_run]    = caddr_rd;
                    obs_wr[busy_run]    = caddr_wr;
                    obs_csel[busy_run]  = csel;
                end
                busy_run++;
            end else begin
                checks++;
                if (mac_en || mac_clr || crd || cwr || csel || pool_en || pool_clr ||
                    caddr_rd != 12'd0 || caddr_wr != 12'd0 || mac_tap != 4'd0) begin
                    errors++;
                    $display("FAIL idle_quiet: got en=%b clr=%b crd=%b cwr=%b csel=%b pen=%b pclr=%b rd=%0d wr=%0d tap=%0d, expected all 0",
                             mac_en, mac_clr, crd, cwr, csel, pool_en, pool_clr, caddr_rd, caddr_wr, mac_tap);
                end
            end
            if (run_no == 2 && !reset) begin
                if (mac_en && mac_tap < 4'd9) begin
                    v   = w[int'(mac_tap)] * img[int'(iaddr)];
                    acc = mac_clr ? v : acc + v;
                end
                if (crd && pool_en) begin
                    v    = mem0[int'(caddr_rd)];
                    pmax = (pool_clr || v > pmax) ? v : pmax;
                end
                if (cwr) begin
                    v = out_sel ? roundup16(pmax) : relu(acc + bias);
                    if (!csel) begin
                        mem0[int'(caddr_wr)] = v;
                        wc0[int'(caddr_wr)]++;
                    end else begin
                        mem1[int'(caddr_wr[9:0])] = v;
                        wc1[int'(caddr_wr[9:0])]++;
                    end
                end
            end
            if (errors >= 100) begin
                $display("FAIL error_limit: got %0d errors, expected fewer than 100", errors);
                finish_sim();
            end
        end
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL timeout: got no completion, expected finish before 800000");
        finish_sim();
    end

    initial begin
        int fell;
        int gap;
        int c0[9]  = '{0, 0, 2, 0, 0, 2, 128, 128, 130};
        int c1[9]  = '{0, 1, 3, 0, 1, 3, 128, 129, 131};
        int cl[9]  = '{3965, 3967, 3967, 4093, 4095, 4095, 4093, 4095, 4095};
        int pr0[4] = '{0, 1, 64, 65};
        int prl[4] = '{4030, 4031, 4094, 4095};

        reset = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 15)) - 8;
        bias = int'($urandom_range(0, 200)) - 400;
        for (int a = 0; a < 4096; a++) img[a] = int'($urandom_range(0, 255));
        for (int p = 0; p < 4096; p++) begin
            int s;
            s = bias;
            for (int i = 0; i < 3; i++)
                for (int jj = 0; jj < 3; jj++)
                    s += w[3 * i + jj] * img[clampi(p / 64 + 2 * i - 2) * 64 + clampi(p % 64 + 2 * jj - 2)];
            gold0[p] = relu(s);
        end
        for (int qq = 0; qq < 1024; qq++) begin
            int m;
            int b;
            b = (qq / 32) * 128 + (qq % 32) * 2;
            m = gold0[b];
            if (gold0[b + 1] > m) m = gold0[b + 1];
            if (gold0[b + 64] > m) m = gold0[b + 64];
            if (gold0[b + 65] > m) m = gold0[b + 65];
            gold1[qq] = roundup16(m);
        end

        // reset held with ready high: outputs stay 0
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("reset_busy", int'(busy), 0);
            chk("reset_iaddr", int'(iaddr), 0);
            chk("reset_out_sel", int'(out_sel), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push_run();
        @(negedge clk);
        chk("start_idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("start_busy", int'(busy), 1);
        chk("start_iaddr", int'(iaddr), 0);
        chk("start_mac_clr", int'(mac_clr), 1);
        chk("start_mac_tap", int'(mac_tap), 0);

        // run A: reset around cycle 20000
        repeat (19990) @(posedge clk);
        #1;
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_cwr", int'(cwr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_without_ready", int'(busy), 0);

        // run B: full run, ready toggled randomly while busy, then held high past DONE
        @(posedge clk); #1;
        push_run();
        ready = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 46070; n++) begin
            ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ready = 1'b1;
        fell = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1;
                break;
            end
        end
        chk("runB_busy_fell", fell, 1);
        chk("runB_queue_drained", exp_q.size(), 0);
        push_run();
        gap = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy) break;
            gap++;
        end
        chk("restart_gap", gap, 2);
        chk("runB_busy_len", last_len, RUN_LEN);

        // run C: let it start, then stop it with reset
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("runC_reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // schedule corners observed during run B
        for (int k = 0; k < 9; k++) begin
            chk("tap_p0", int'(obs_iaddr[k]), c0[k]);
            chk("tap_p1", int'(obs_iaddr[10 + k]), c1[k]);
            chk("tap_p4095", int'(obs_iaddr[40950 + k]), cl[k]);
        end
        chk("wr0_p0_addr", int'(obs_wr[9]), 0);
        chk("wr0_p0_csel", int'(obs_csel[9]), 0);
        chk("wr0_p1_addr", int'(obs_wr[19]), 1);
        chk("wr0_p4095_addr", int'(obs_wr[40959]), 4095);
        chk("wr0_p4095_csel", int'(obs_csel[40959]), 0);
        for (int m = 0; m < 4; m++) begin
            chk("pool_q0_rd", int'(obs_rd[40960 + m]), pr0[m]);
            chk("pool_q0_csel", int'(obs_csel[40960 + m]), 0);
            chk("pool_q1023_rd", int'(obs_rd[46075 + m]), prl[m]);
        end
        chk("wr1_q0_addr", int'(obs_wr[40964]), 0);
        chk("wr1_q0_csel", int'(obs_csel[40964]), 1);
        chk("wr1_q1023_addr", int'(obs_wr[46079]), 1023);
        chk("wr1_q1023_csel", int'(obs_csel[46079]), 1);

        // end-to-end data and single-write coverage
        for (int a = 0; a < 4096; a++) begin
            checks++;
            if (mem0[a] != gold0[a] || wc0[a] != 1) begin
                errors++;
                $display("FAIL layer0[%0d]: got %0d (writes %0d), expected %0d (writes 1)", a, mem0[a], wc0[a], gold0[a]);
            end
        end
        for (int a = 0; a < 1024; a++) begin
            checks++;
            if (mem1[a] != gold1[a] || wc1[a] != 1) begin
                errors++;
                $display("FAIL layer1[%0d]: got %0d (writes %0d), expected %0d (writes 1)", a, mem1[a], wc1[a], gold1[a]);
            end
        end
        finish_sim();
    end

endmodule
